row_unload_responder: RTL and testbench

//  Memory-bank side of the unload1/unload2/unload3 strobe interface driven by the sequencing controller.

---
 rtl/mm_pkg.sv | 17 +
 rtl/unload_req_arbiter.sv | 58 +++++
 rtl/row_unload_responder.sv | 164 ++++++++++++++++
 tb/tb_row_unload_responder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the row unload responder.
//   ROWS    : fixed number of matrix rows, one per unload strobe
//   row_t   : row index type (0..2)
//   state_t : responder FSM states
package mm_pkg;

   localparam int unsigned ROWS = 3;

   typedef logic [1:0] row_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      ACK    = 2'd2
   } state_t;

endpackage

// File: rtl/unload_req_arbiter.sv
// Unload request arbiter: rising-edge detection on the three unload strobes,
// sticky pending bits and fixed-priority row selection (row 0 highest).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   unload    : raw unload strobes, bit k requests row k
//   take      : the selected row is entering STREAM this cycle
//   pend_any  : some row is pending (including a request seen this cycle)
//   sel_row   : lowest pending row index
module unload_req_arbiter
   import mm_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] unload,
   input  logic            take,
   output logic            pend_any,
   output logic [1:0]      sel_row
);

   logic [ROWS-1:0] prev_q, prev_d;
   logic [ROWS-1:0] pend_q, pend_d;
   logic [ROWS-1:0] req;
   logic [ROWS-1:0] pend_eff;
   logic [ROWS-1:0] sel_hot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= '0;
         pend_q <= '0;
      end else begin
         prev_q <= prev_d;
         pend_q <= pend_d;
      end
   end

   always_comb begin
      prev_d   = unload;
      req      = unload & ~prev_q;
      // A request arriving this cycle is eligible for selection immediately.
      pend_eff = pend_q | req;
      pend_any = |pend_eff;
      sel_row  = 2'd0;
      sel_hot  = '0;
      if (pend_eff[0]) begin
         sel_row = 2'd0;
         sel_hot = 3'b001;
      end else if (pend_eff[1]) begin
         sel_row = 2'd1;
         sel_hot = 3'b010;
      end else if (pend_eff[2]) begin
         sel_row = 2'd2;
         sel_hot = 3'b100;
      end
      // Clearing after the OR merges a same-cycle repeat for the granted row.
      pend_d = pend_eff & ~(take ? sel_hot : '0);
   end

endmodule

// File: rtl/row_unload_responder.sv
// Row unload responder: holds a 3 x COLS operand matrix written word by word,
// and on each unload strobe streams the selected row over valid/ready,
// followed by a one-cycle row_done pulse.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   unload1..3           : row 0..2 requests (rising edge counted)
//   wr_en/wr_addr/wr_data: matrix write port, address = row*COLS + col
//   out_data/out_valid   : streamed element and its valid
//   out_ready            : consumer accept
//   out_row/out_last     : row being streamed, final element flag
//   row_done             : one-cycle pulse after the last element is accepted
//   busy                 : high in STREAM and ACK
//   wr_err               : write rejected (busy or address out of range)
//   out_parity           : even parity of out_data, only with UNLOAD_PARITY_EN
// Optional feature macro: UNLOAD_PARITY_EN
module row_unload_responder
   import mm_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned COLS   = 3,
   parameter int unsigned ADDR_W = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              unload1,
   input  logic              unload2,
   input  logic              unload3,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_row,
   output logic              out_last,
   output logic              row_done,
   output logic              busy,
   output logic              wr_err
`ifdef UNLOAD_PARITY_EN
   ,
   output logic              out_parity
`endif
);

   localparam int unsigned NELEM = ROWS * COLS;
   localparam int unsigned COL_W = $clog2(COLS);

   state_t            state_q, state_d;
   logic [1:0]        row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [DATA_W-1:0] mem_q [NELEM];
   logic [DATA_W-1:0] mem_d [NELEM];

   logic              pend_any;
   logic [1:0]        sel_row;
   logic              take;
   logic              col_last;
   logic              wr_ok;
   logic              streaming;
   int unsigned       rd_idx;
   logic [DATA_W-1:0] rd_data;

   unload_req_arbiter u_arb (
      .clk      (clk),
      .rst      (rst),
      .unload   ({unload3, unload2, unload1}),
      .take     (take),
      .pend_any (pend_any),
      .sel_row  (sel_row)
   );

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // Matrix storage survives reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      col_last = (col_q == COL_W'(COLS - 1));
      take     = (state_q == IDLE) && pend_any;
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      case (state_q)
         IDLE: begin
            if (pend_any) begin
               state_d = STREAM;
               row_d   = sel_row;
               col_d   = '0;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (col_last) begin
                  state_d = ACK;
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Write acceptance and storage update.
   always_comb begin
      wr_ok = wr_en && (state_q == IDLE) && (32'(wr_addr) < NELEM);
      mem_d = mem_q;
      for (int unsigned i = 0; i < NELEM; i++) begin
         if (wr_ok && (32'(wr_addr) == i)) begin
            mem_d[i] = wr_data;
         end
      end
   end

   // Element read for the current row/column.
   always_comb begin
      rd_idx  = 32'(row_q) * COLS + 32'(col_q);
      rd_data = '0;
      for (int unsigned i = 0; i < NELEM; i++) begin
         if (rd_idx == i) begin
            rd_data = mem_q[i];
         end
      end
   end

   // ---------------- output logic ----------------
   always_comb begin
      streaming = (state_q == STREAM);
      out_valid = streaming;
      out_data  = streaming ? rd_data : '0;
      out_last  = streaming && col_last;
      out_row   = row_q;
      row_done  = (state_q == ACK);
      busy      = (state_q != IDLE);
      wr_err    = wr_en && !wr_ok;
   end

`ifdef UNLOAD_PARITY_EN
   always_comb begin
      out_parity = ^out_data;
   end
`endif

endmodule

// File: tb/tb_row_unload_responder.sv
module tb_row_unload_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       unload1, unload2, unload3;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_row;
   logic       out_last;
   logic       row_done;
   logic       busy;
   logic       wr_err;
`ifdef UNLOAD_PARITY_EN
   logic       out_parity;
`endif

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   row_unload_responder #(
      .DATA_W (8),
      .COLS   (3),
      .ADDR_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .unload1   (unload1),
      .unload2   (unload2),
      .unload3   (unload3),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .out_last  (out_last),
      .row_done  (row_done),
      .busy      (busy),
      .wr_err    (wr_err)
`ifdef UNLOAD_PARITY_EN
      ,
      .out_parity(out_parity)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to 2 time units after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input logic [3:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      cyc();
      wr_en   = 1'b0;
   endtask

   task automatic elem(input string tag, input logic [7:0] d, input logic [1:0] r, input logic l);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"},  out_data,  d);
      check({tag, "_row"},   out_row,   r);
      check({tag, "_last"},  out_last,  l);
   endtask

   task automatic done_cycle(input string tag);
      check({tag, "_done"},  row_done,  1);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_busy"},  busy,      1);
   endtask

   initial begin
      rst       = 1'b1;
      unload1   = 1'b0;
      unload2   = 1'b0;
      unload3   = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      // Reset state
      check("rst_valid", out_valid, 0);
      check("rst_done",  row_done,  0);
      check("rst_busy",  busy,      0);
      check("rst_werr",  wr_err,    0);
      check("rst_data",  out_data,  0);
      check("rst_row",   out_row,   0);
      check("rst_last",  out_last,  0);
`ifdef UNLOAD_PARITY_EN
      check("rst_par",   out_parity, 0);
`endif
      rst = 1'b0;
      cyc();

      for (int i = 0; i < 9; i++) load(4'(i), 8'(i + 1));

      // Row 0, full throughput
      unload1 = 1'b1;
      #1 check("t1_pre_valid", out_valid, 0);
      cyc();
      unload1 = 1'b0;
      elem("t1_e0", 8'd1, 2'd0, 1'b0);
      cyc();
      elem("t1_e1", 8'd2, 2'd0, 1'b0);
      cyc();
      elem("t1_e2", 8'd3, 2'd0, 1'b1);
      cyc();
      done_cycle("t1_ack");
      cyc();
      check("t1_done_low", row_done, 0);
      check("t1_idle_busy", busy, 0);

      // Row 1 with a two-cycle stall on the second element, level held high
      unload2 = 1'b1;
      cyc();
      elem("t2_e0", 8'd4, 2'd1, 1'b0);
      cyc();
      elem("t2_e1", 8'd5, 2'd1, 1'b0);
      out_ready = 1'b0;
      cyc();
      elem("t2_stall1", 8'd5, 2'd1, 1'b0);
      cyc();
      elem("t2_stall2", 8'd5, 2'd1, 1'b0);
      out_ready = 1'b1;
      cyc();
      elem("t2_e2", 8'd6, 2'd1, 1'b1);
      cyc();
      done_cycle("t2_ack");
      cyc();
      cyc();
      cyc();
      check("t2_level_once", out_valid, 0);
      unload2 = 1'b0;
      cyc();

      // Rows 1 and 2 requested together: row 1 first
      unload2 = 1'b1;
      unload3 = 1'b1;
      cyc();
      unload2 = 1'b0;
      unload3 = 1'b0;
      elem("t3_r1e0", 8'd4, 2'd1, 1'b0);
      cyc();
      elem("t3_r1e1", 8'd5, 2'd1, 1'b0);
      cyc();
      elem("t3_r1e2", 8'd6, 2'd1, 1'b1);
      cyc();
      done_cycle("t3_r1ack");
      cyc();
      check("t3_gap_valid", out_valid, 0);
      cyc();
      elem("t3_r2e0", 8'd7, 2'd2, 1'b0);
      cyc();
      elem("t3_r2e1", 8'd8, 2'd2, 1'b0);
      cyc();
      elem("t3_r2e2", 8'd9, 2'd2, 1'b1);
      cyc();
      done_cycle("t3_r2ack");
      cyc();

      // Row 2 requested while row 0 streams
      unload1 = 1'b1;
      cyc();
      unload1 = 1'b0;
      elem("t4_r0e0", 8'd1, 2'd0, 1'b0);
      cyc();
      elem("t4_r0e1", 8'd2, 2'd0, 1'b0);
      unload3 = 1'b1;
      cyc();
      unload3 = 1'b0;
      elem("t4_r0e2", 8'd3, 2'd0, 1'b1);
      cyc();
      done_cycle("t4_r0ack");
      cyc();
      check("t4_gap_valid", out_valid, 0);
      cyc();
      elem("t4_r2e0", 8'd7, 2'd2, 1'b0);
      cyc();
      elem("t4_r2e1", 8'd8, 2'd2, 1'b0);
      cyc();
      elem("t4_r2e2", 8'd9, 2'd2, 1'b1);
      cyc();
      done_cycle("t4_r2ack");
      cyc();

      // Rejected writes: while busy, and out-of-range address in IDLE
      unload1 = 1'b1;
      cyc();
      unload1 = 1'b0;
      elem("t5_e0", 8'd1, 2'd0, 1'b0);
      wr_en   = 1'b1;
      wr_addr = 4'd0;
      wr_data = 8'hAA;
      #1 check("t5_busy_werr", wr_err, 1);
      cyc();
      wr_en = 1'b0;
      #1 check("t5_werr_low", wr_err, 0);
      elem("t5_e1", 8'd2, 2'd0, 1'b0);
      cyc();
      elem("t5_e2", 8'd3, 2'd0, 1'b1);
      cyc();
      done_cycle("t5_ack");
      cyc();
      wr_en   = 1'b1;
      wr_addr = 4'd9;
      wr_data = 8'h55;
      #1 check("t5_range_werr", wr_err, 1);
      cyc();
      wr_addr = 4'd4;
      wr_data = 8'd5;
      #1 check("t5_ok_werr", wr_err, 0);
      cyc();
      wr_en = 1'b0;
      unload1 = 1'b1;
      cyc();
      unload1 = 1'b0;
      elem("t5_chk_e0", 8'd1, 2'd0, 1'b0);
      cyc();
      elem("t5_chk_e1", 8'd2, 2'd0, 1'b0);
      cyc();
      elem("t5_chk_e2", 8'd3, 2'd0, 1'b1);
      cyc();
      done_cycle("t5_chk_ack");
      cyc();

      // Reset after the second element of row 0 is accepted
      unload1 = 1'b1;
      cyc();
      unload1 = 1'b0;
      elem("t6_e0", 8'd1, 2'd0, 1'b0);
      cyc();
      elem("t6_e1", 8'd2, 2'd0, 1'b0);
      cyc();
      elem("t6_e2", 8'd3, 2'd0, 1'b1);
      rst = 1'b1;
      #1;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_data",  out_data,  0);
      check("t6_rst_row",   out_row,   0);
      check("t6_rst_last",  out_last,  0);
      check("t6_rst_busy",  busy,      0);
      check("t6_rst_done",  row_done,  0);
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("t6_post_done",  row_done,  0);
         check("t6_post_valid", out_valid, 0);
      end
      unload1 = 1'b1;
      cyc();
      unload1 = 1'b0;
      elem("t6_mem_e0", 8'd1, 2'd0, 1'b0);
      cyc();
      cyc();
      cyc();
      done_cycle("t6_mem_ack");
      cyc();

`ifdef UNLOAD_PARITY_EN
      load(4'd0, 8'h07);
      unload1 = 1'b1;
      cyc();
      unload1 = 1'b0;
      elem("t7_e0", 8'h07, 2'd0, 1'b0);
      check("t7_par0", out_parity, 1);
      cyc();
      elem("t7_e1", 8'h02, 2'd0, 1'b0);
      check("t7_par1", out_parity, 1);
      cyc();
      elem("t7_e2", 8'h03, 2'd0, 1'b1);
      check("t7_par2", out_parity, 0);
      cyc();
      done_cycle("t7_ack");
      check("t7_par_idle", out_parity, 0);
      cyc();
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
